sram_access_scheduler: RTL and testbench

- Time-multiplexes the single external 16-bit SRAM between three requesters:
  - record writer (ADC path),
  - playback reader (DAC path),
  - visualiser reader (spectrum/waveform display).
- Replaces the direct state-based mux of SRAM address/data in the top level, so playback and visualisation can read while recording is possible.
- Owns all SRAM control pins and the DQ tristate.

---
 rtl/sram_access_scheduler.sv | 149 ++++++++++++++
 tb/tb_sram_access_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sram_access_scheduler.sv
// Time-multiplexes one asynchronous 16-bit SRAM between record writer, playback
// reader and visualiser reader; owns all SRAM control pins and the DQ tristate.
module sram_access_scheduler #(
  parameter int ACC_CYC    = 3,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 20,
  parameter int DW         = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_req,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ack,
  input  logic          i_pl_req,
  input  logic [AW-1:0] i_pl_addr,
  output logic [DW-1:0] o_pl_data,
  output logic          o_pl_valid,
  input  logic          i_vz_req,
  input  logic [AW-1:0] i_vz_addr,
  output logic [DW-1:0] o_vz_data,
  output logic          o_vz_valid,
  output logic [AW-1:0] o_sram_addr,
  inout  logic [DW-1:0] io_sram_dq,
  output logic          o_sram_ce_n,
  output logic          o_sram_ub_n,
  output logic          o_sram_lb_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n,
  output logic          o_busy
);

  localparam int CW = $clog2(ACC_CYC + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {GNT_WR, GNT_PL, GNT_VZ} gnt_t;

  state_t        state;
  gnt_t          gnt;
  gnt_t          gnt_nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic [DW-1:0] wdata_q;
  logic          dq_oe;
  logic          any_req;
  logic          vz_force;
  logic [AW-1:0] addr_nxt;

  assign o_sram_ce_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign o_sram_lb_n = 1'b0;

  assign io_sram_dq = dq_oe ? wdata_q : 'z;

  // Starved visualiser overrides the fixed write > playback > visualiser order.
  always_comb begin
    any_req  = i_wr_req | i_pl_req | i_vz_req;
    vz_force = i_vz_req && (starve == SW'(STARVE_MAX));
    gnt_nxt  = GNT_VZ;
    addr_nxt = i_vz_addr;
    if (vz_force) begin
      gnt_nxt  = GNT_VZ;
      addr_nxt = i_vz_addr;
    end else if (i_wr_req) begin
      gnt_nxt  = GNT_WR;
      addr_nxt = i_wr_addr;
    end else if (i_pl_req) begin
      gnt_nxt  = GNT_PL;
      addr_nxt = i_pl_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      gnt         <= GNT_WR;
      cnt         <= '0;
      starve      <= '0;
      wdata_q     <= '0;
      dq_oe       <= 1'b0;
      o_sram_addr <= '0;
      o_sram_we_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_wr_ack    <= 1'b0;
      o_pl_valid  <= 1'b0;
      o_vz_valid  <= 1'b0;
      o_pl_data   <= '0;
      o_vz_data   <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_wr_ack   <= 1'b0;
      o_pl_valid <= 1'b0;
      o_vz_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ACCESS;
            gnt         <= gnt_nxt;
            cnt         <= '0;
            o_busy      <= 1'b1;
            o_sram_addr <= addr_nxt;
            wdata_q     <= i_wr_data;
            if (gnt_nxt == GNT_WR) begin
              dq_oe       <= 1'b1;
              o_sram_we_n <= 1'b0;
            end else begin
              o_sram_oe_n <= 1'b0;
            end
            if (gnt_nxt == GNT_VZ)
              starve <= '0;
            else if (i_vz_req && (starve != SW'(STARVE_MAX)))
              starve <= starve + SW'(1);
          end
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          // Release we_n one cycle early so DQ is held past the write strobe.
          if (cnt == CW'(ACC_CYC - 2))
            o_sram_we_n <= 1'b1;
          if (cnt == CW'(ACC_CYC - 1)) begin
            state       <= DONE;
            dq_oe       <= 1'b0;
            o_sram_we_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            case (gnt)
              GNT_WR: o_wr_ack <= 1'b1;
              GNT_PL: begin
                o_pl_data  <= io_sram_dq;
                o_pl_valid <= 1'b1;
              end
              GNT_VZ: begin
                o_vz_data  <= io_sram_dq;
                o_vz_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_scheduler.sv
// Directed per-cycle vectors for sram_access_scheduler against a small SRAM model,
// plus a hand-written starvation sequence.
module tb_sram_access_scheduler;

  localparam logic [1:0]  DQ_X  = 2'd0;
  localparam logic [1:0]  DQ_Z  = 2'd1;
  localparam logic [1:0]  DQ_D  = 2'd2;
  localparam logic [15:0] PROBE = 16'h5A3C;
  localparam int          NV    = 41;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0, pl_req = 1'b0, vz_req = 1'b0;
  logic [19:0] wr_addr = '0, pl_addr = '0, vz_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack, pl_valid, vz_valid;
  logic [15:0] pl_data, vz_data;
  logic [19:0] sram_addr;
  logic        ce_n, ub_n, lb_n, oe_n, we_n, busy;
  wire  [15:0] dq;

  logic        probe_on = 1'b0;
  logic [15:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // SRAM model; when probe_on the bench drives a marker so a stray DUT drive corrupts it.
  assign dq = probe_on ? PROBE : ((!oe_n && we_n) ? mem[sram_addr[7:0]] : 'z);

  always @(negedge clk)
    if (!we_n) mem[sram_addr[7:0]] <= dq;

  sram_access_scheduler #(.ACC_CYC(3), .STARVE_MAX(4), .AW(20), .DW(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_pl_req(pl_req), .i_pl_addr(pl_addr), .o_pl_data(pl_data), .o_pl_valid(pl_valid),
    .i_vz_req(vz_req), .i_vz_addr(vz_addr), .o_vz_data(vz_data), .o_vz_valid(vz_valid),
    .o_sram_addr(sram_addr), .io_sram_dq(dq),
    .o_sram_ce_n(ce_n), .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n),
    .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_busy(busy)
  );

  // in = {rst, wr, pl, vz}; ctl = {busy, we_n, oe_n}; pls = {wr_ack, pl_valid, vz_valid}
  typedef struct {
    logic [3:0]  in;
    logic [19:0] wa;
    logic [15:0] wd;
    logic [19:0] pa;
    logic [19:0] va;
    logic [2:0]  ctl;
    logic [19:0] addr;
    logic [1:0]  dqk;
    logic [15:0] dqv;
    logic [2:0]  pls;
    logic [15:0] pld;
    logic [15:0] vzd;
  } vec_t;

  vec_t tv [NV];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
      n_bad++;
    end
  endtask

  initial begin
    // single write 0x10 <= A5A5
    tv[0]  = '{4'b1000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b011, 20'h0,  DQ_Z, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[1]  = '{4'b0100, 20'h10, 16'hA5A5, 20'h0,  20'h0,  3'b011, 20'h0,  DQ_Z, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[2]  = '{4'b0100, 20'h10, 16'hA5A5, 20'h0,  20'h0,  3'b101, 20'h10, DQ_D, 16'hA5A5, 3'b000, 16'h0,    16'h0};
    tv[3]  = '{4'b0100, 20'h10, 16'hA5A5, 20'h0,  20'h0,  3'b101, 20'h10, DQ_D, 16'hA5A5, 3'b000, 16'h0,    16'h0};
    tv[4]  = '{4'b0100, 20'h10, 16'hA5A5, 20'h0,  20'h0,  3'b111, 20'h10, DQ_D, 16'hA5A5, 3'b000, 16'h0,    16'h0};
    tv[5]  = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b111, 20'h10, DQ_Z, 16'h0,    3'b100, 16'h0,    16'h0};
    // playback read-back of 0x10
    tv[6]  = '{4'b0010, 20'h0,  16'h0,    20'h10, 20'h0,  3'b011, 20'h10, DQ_Z, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[7]  = '{4'b0010, 20'h0,  16'h0,    20'h10, 20'h0,  3'b110, 20'h10, DQ_X, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[8]  = '{4'b0010, 20'h0,  16'h0,    20'h10, 20'h0,  3'b110, 20'h10, DQ_X, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[9]  = '{4'b0010, 20'h0,  16'h0,    20'h10, 20'h0,  3'b110, 20'h10, DQ_X, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[10] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b111, 20'h10, DQ_Z, 16'h0,    3'b010, 16'hA5A5, 16'h0};
    // all three together: write, then playback, then visualiser
    tv[11] = '{4'b0111, 20'h20, 16'h1234, 20'h10, 20'h20, 3'b011, 20'h10, DQ_Z, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[12] = '{4'b0111, 20'h20, 16'h1234, 20'h10, 20'h20, 3'b101, 20'h20, DQ_D, 16'h1234, 3'b000, 16'hA5A5, 16'h0};
    tv[13] = '{4'b0111, 20'h20, 16'h1234, 20'h10, 20'h20, 3'b101, 20'h20, DQ_D, 16'h1234, 3'b000, 16'hA5A5, 16'h0};
    tv[14] = '{4'b0111, 20'h20, 16'h1234, 20'h10, 20'h20, 3'b111, 20'h20, DQ_D, 16'h1234, 3'b000, 16'hA5A5, 16'h0};
    tv[15] = '{4'b0011, 20'h0,  16'h0,    20'h10, 20'h20, 3'b111, 20'h20, DQ_Z, 16'h0,    3'b100, 16'hA5A5, 16'h0};
    tv[16] = '{4'b0011, 20'h0,  16'h0,    20'h10, 20'h20, 3'b011, 20'h20, DQ_Z, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[17] = '{4'b0011, 20'h0,  16'h0,    20'h10, 20'h20, 3'b110, 20'h10, DQ_X, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[18] = '{4'b0011, 20'h0,  16'h0,    20'h10, 20'h20, 3'b110, 20'h10, DQ_X, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[19] = '{4'b0011, 20'h0,  16'h0,    20'h10, 20'h20, 3'b110, 20'h10, DQ_X, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[20] = '{4'b0001, 20'h0,  16'h0,    20'h0,  20'h20, 3'b111, 20'h10, DQ_Z, 16'h0,    3'b010, 16'hA5A5, 16'h0};
    tv[21] = '{4'b0001, 20'h0,  16'h0,    20'h0,  20'h20, 3'b011, 20'h10, DQ_Z, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[22] = '{4'b0001, 20'h0,  16'h0,    20'h0,  20'h20, 3'b110, 20'h20, DQ_X, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[23] = '{4'b0001, 20'h0,  16'h0,    20'h0,  20'h20, 3'b110, 20'h20, DQ_X, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[24] = '{4'b0001, 20'h0,  16'h0,    20'h0,  20'h20, 3'b110, 20'h20, DQ_X, 16'h0,    3'b000, 16'hA5A5, 16'h0};
    tv[25] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b111, 20'h20, DQ_Z, 16'h0,    3'b001, 16'hA5A5, 16'h1234};
    // reset asserted in the second write cycle, then the held request restarts
    tv[26] = '{4'b0100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b011, 20'h20, DQ_Z, 16'h0,    3'b000, 16'hA5A5, 16'h1234};
    tv[27] = '{4'b0100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b101, 20'h40, DQ_D, 16'h0F0F, 3'b000, 16'hA5A5, 16'h1234};
    tv[28] = '{4'b1100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b011, 20'h0,  DQ_Z, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[29] = '{4'b0100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b011, 20'h0,  DQ_Z, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[30] = '{4'b0100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b101, 20'h40, DQ_D, 16'h0F0F, 3'b000, 16'h0,    16'h0};
    tv[31] = '{4'b0100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b101, 20'h40, DQ_D, 16'h0F0F, 3'b000, 16'h0,    16'h0};
    tv[32] = '{4'b0100, 20'h40, 16'h0F0F, 20'h0,  20'h0,  3'b111, 20'h40, DQ_D, 16'h0F0F, 3'b000, 16'h0,    16'h0};
    tv[33] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b111, 20'h40, DQ_Z, 16'h0,    3'b100, 16'h0,    16'h0};
    // playback request dropped in the second access cycle
    tv[34] = '{4'b0010, 20'h0,  16'h0,    20'h40, 20'h0,  3'b011, 20'h40, DQ_Z, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[35] = '{4'b0010, 20'h0,  16'h0,    20'h40, 20'h0,  3'b110, 20'h40, DQ_X, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[36] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b110, 20'h40, DQ_X, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[37] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b110, 20'h40, DQ_X, 16'h0,    3'b000, 16'h0,    16'h0};
    tv[38] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b111, 20'h40, DQ_Z, 16'h0,    3'b010, 16'h0F0F, 16'h0};
    tv[39] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b011, 20'h40, DQ_Z, 16'h0,    3'b000, 16'h0F0F, 16'h0};
    tv[40] = '{4'b0000, 20'h0,  16'h0,    20'h0,  20'h0,  3'b011, 20'h40, DQ_Z, 16'h0,    3'b000, 16'h0F0F, 16'h0};

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      {rst, wr_req, pl_req, vz_req} = tv[i].in;
      wr_addr  = tv[i].wa;
      wr_data  = tv[i].wd;
      pl_addr  = tv[i].pa;
      vz_addr  = tv[i].va;
      probe_on = (tv[i].dqk == DQ_Z);
      @(negedge clk);
      n_vec++;
      chk("busy",     i, 32'(busy),     32'(tv[i].ctl[2]));
      chk("we_n",     i, 32'(we_n),     32'(tv[i].ctl[1]));
      chk("oe_n",     i, 32'(oe_n),     32'(tv[i].ctl[0]));
      chk("ce_ub_lb", i, 32'({ce_n, ub_n, lb_n}), 32'(3'b000));
      chk("addr",     i, 32'(sram_addr), 32'(tv[i].addr));
      if (tv[i].dqk == DQ_Z) chk("dq_hiz", i, 32'(dq), 32'(PROBE));
      if (tv[i].dqk == DQ_D) chk("dq_drv", i, 32'(dq), 32'(tv[i].dqv));
      chk("wr_ack",   i, 32'(wr_ack),   32'(tv[i].pls[2]));
      chk("pl_valid", i, 32'(pl_valid), 32'(tv[i].pls[1]));
      chk("vz_valid", i, 32'(vz_valid), 32'(tv[i].pls[0]));
      chk("pl_data",  i, 32'(pl_data),  32'(tv[i].pld));
      chk("vz_data",  i, 32'(vz_data),  32'(tv[i].vzd));
    end

    // Writer and visualiser both held: visualiser wins every fifth arbitration.
    @(posedge clk);
    #1;
    probe_on = 1'b0;
    wr_req = 1'b1; wr_addr = 20'h50; wr_data = 16'hC3C3;
    vz_req = 1'b1; vz_addr = 20'h10;
    pl_req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      logic vz_win;
      logic is_done;
      is_done = ((c % 5) == 4);
      vz_win  = is_done && (((c / 5) % 5) == 4);
      @(negedge clk);
      n_vec++;
      chk("starve_wr_ack",   100 + c, 32'(wr_ack),   32'(is_done && !vz_win));
      chk("starve_vz_valid", 100 + c, 32'(vz_valid), 32'(vz_win));
      if (vz_win) chk("starve_vz_data", 100 + c, 32'(vz_data), 32'(16'hA5A5));
      if (c != 49) @(posedge clk);
    end
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    vz_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      chk("drain_busy", 200 + c, 32'(busy), 32'(1'b0));
      chk("drain_oe_n", 200 + c, 32'(oe_n), 32'(1'b1));
      chk("drain_we_n", 200 + c, 32'(we_n), 32'(1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
